// File: rtl/matvec_mul_stream.sv
// Streaming signed matrix-vector multiplier: product stage, pairwise adder tree and a
// cross-tile accumulator with rounding, shift and saturation onto a valid/ready output.
module matvec_mul_stream #(
  parameter int R         = 4,
  parameter int C         = 4,
  parameter int W_X       = 8,
  parameter int W_K       = 8,
  parameter int MAX_TILES = 4,
  parameter int W_Y       = 16,
  parameter int SHIFT     = 0
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_last,
  input  logic [R-1:0][C-1:0][W_K-1:0]    s_k,
  input  logic [C-1:0][W_X-1:0]           s_x,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [R-1:0][W_Y-1:0]           m_y,
  output logic                            m_sat
);

  localparam int C_PAD = 2 ** $clog2(C);
  localparam int DEPTH = $clog2(C_PAD);
  localparam int W_P   = W_X + W_K;
  localparam int W_S   = W_P + DEPTH;
  localparam int W_ACC = W_P + DEPTH + $clog2(MAX_TILES) + 1;
  localparam int W_R   = (W_ACC + 1 > W_Y) ? W_ACC + 1 : W_Y + 1;
  localparam int BIAS  = (2 ** SHIFT) / 2;

  localparam logic signed [W_R-1:0] Y_MAX = {{(W_R-W_Y+1){1'b0}}, {(W_Y-1){1'b1}}};
  localparam logic signed [W_R-1:0] Y_MIN = {{(W_R-W_Y+1){1'b1}}, {(W_Y-1){1'b0}}};

  logic                     en;
  logic [DEPTH:0]           vld_q;
  logic [DEPTH:0]           lst_q;
  logic signed [W_S-1:0]    tree_q [DEPTH+1][R][C_PAD];
  logic signed [W_ACC-1:0]  acc_q  [R];
  logic signed [W_ACC-1:0]  acc_d  [R];
  logic signed [W_R-1:0]    rnd    [R];
  logic [R-1:0][W_Y-1:0]    y_d;
  logic [R-1:0]             sat_d;
  logic                     m_valid_q;
  logic                     m_sat_q;
  logic [R-1:0][W_Y-1:0]    m_y_q;

  // One global enable: the whole pipeline, bubbles included, freezes under backpressure.
  assign en      = !m_valid_q || m_ready;
  assign s_ready = en;
  assign m_valid = m_valid_q;
  assign m_y     = m_y_q;
  assign m_sat   = m_sat_q;

  function automatic logic signed [W_P-1:0] mul(input logic [W_K-1:0] k, input logic [W_X-1:0] x);
    logic signed [W_P-1:0] ke;
    logic signed [W_P-1:0] xe;
    ke = W_P'($signed(k));
    xe = W_P'($signed(x));
    return ke * xe;
  endfunction

  // NOTE: datapath registers carry no reset; their contents are ignored unless the
  // matching valid tag is set, and only the valids and accumulators need a known value.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++)
          tree_q[0][r][c] <= W_S'(mul(s_k[r][c], s_x[c]));
        for (int c = C; c < C_PAD; c++)
          tree_q[0][r][c] <= '0;
        for (int d = 1; d <= DEPTH; d++)
          for (int i = 0; i < (C_PAD >> d); i++)
            tree_q[d][r][i] <= tree_q[d-1][r][2*i] + tree_q[d-1][r][2*i+1];
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    y_d   = '0;
    sat_d = '0;
    for (int r = 0; r < R; r++) begin
      acc_d[r] = acc_q[r] + W_ACC'(tree_q[DEPTH][r][0]);
      rnd[r]   = (W_R'(acc_d[r]) + W_R'(BIAS)) >>> SHIFT;
      if (rnd[r] > Y_MAX) begin
        y_d[r]   = Y_MAX[W_Y-1:0];
        sat_d[r] = 1'b1;
      end else if (rnd[r] < Y_MIN) begin
        y_d[r]   = Y_MIN[W_Y-1:0];
        sat_d[r] = 1'b1;
      end else begin
        y_d[r]   = rnd[r][W_Y-1:0];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q     <= '0;
      lst_q     <= '0;
      m_valid_q <= 1'b0;
      m_sat_q   <= 1'b0;
      m_y_q     <= '0;
      for (int r = 0; r < R; r++) acc_q[r] <= '0;
    end else if (en) begin
      vld_q[0] <= s_valid;
      lst_q[0] <= s_last;
      for (int d = 1; d <= DEPTH; d++) begin
        vld_q[d] <= vld_q[d-1];
        lst_q[d] <= lst_q[d-1];
      end
      m_valid_q <= 1'b0;
      if (vld_q[DEPTH]) begin
        if (lst_q[DEPTH]) begin
          m_valid_q <= 1'b1;
          m_y_q     <= y_d;
          m_sat_q   <= |sat_d;
          for (int r = 0; r < R; r++) acc_q[r] <= '0;
        end else begin
          for (int r = 0; r < R; r++) acc_q[r] <= acc_d[r];
        end
      end
    end
  end

endmodule

// File: doc/matvec_mul_stream.md
Name: matvec_mul_stream

Overview:
Streaming, pipelined signed matrix-vector multiplier. It consumes one R×C weight tile and one C-element input tile per handshake. Tile results are accumulated across a variable number of column tiles, so it covers matrices wider than C. Each finished vector is rounded, right-shifted and saturated, then emitted on a valid/ready output. It sits between the UART/AXI-Stream deserialiser and the result serialiser, replacing the free-running cen-gated multiplier where backpressure and wide matrices are needed.

Parameters:
R, 4, rows (output elements per vector)
C, 4, columns per tile; any value ≥1, internally padded to C_PAD = 2**$clog2(C) with zero products
W_X, 8, signed input element width
W_K, 8, signed weight element width
MAX_TILES, 4, tiles per vector guaranteed overflow-free; W_ACC = W_X+W_K+$clog2(C_PAD)+$clog2(MAX_TILES)+1
W_Y, 16, signed output element width
SHIFT, 0, arithmetic right shift applied to the final accumulator before saturation

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
s_valid  in  1  input tile valid
s_ready  out  1  input tile accepted when s_valid&&s_ready
s_last  in  1  final tile of the current vector
s_k  in  R*C*W_K  signed weights, [R-1:0][C-1:0][W_K-1:0]
s_x  in  C*W_X  signed inputs, [C-1:0][W_X-1:0]
m_valid  out  1  result valid
m_ready  in  1  downstream accepts when m_valid&&m_ready
m_y  out  R*W_Y  signed results, [R-1:0][W_Y-1:0]
m_sat  out  1  at least one row of this result saturated

Behaviour:
- Reset (rstn low, async): all pipeline valids, accumulators, m_valid, m_y and m_sat clear to 0. Reset takes effect immediately and cancels any partially accumulated vector; no result is emitted for it.
- Global advance enable: en = !m_valid || m_ready. s_ready = en (combinational). All pipeline stages, including bubbles, move only when en=1, so nothing is lost and m_y holds stable while m_valid && !m_ready.
- Stage M: on accept, register k[r][c]*x[c] for every r and c (full W_X+W_K signed product), plus valid and last tags. A non-accepting cycle with en=1 inserts a bubble (valid=0).
- Stages A1..A_DEPTH, with DEPTH = $clog2(C_PAD): balanced pairwise adder tree, one register level per stage. Valid and last are tagged alongside. Sums are sign-extended, never truncated. For DEPTH=0 (C=1) there are no adder stages.
- Stage O is the accumulator. When a valid tile arrives:
  - not last: acc[r] <= acc[r] + sum[r].
  - last: t = acc[r] + sum[r]; m_y[r] <= sat_W_Y((t + (SHIFT>0 ? 2**(SHIFT-1) : 0)) >>> SHIFT); acc[r] <= 0; m_valid <= 1; m_sat <= OR over rows of the saturation events.
- Rounding is round-half-toward-+inf. Saturation clamps to [-2**(W_Y-1), 2**(W_Y-1)-1].
- If m_valid && m_ready and no new last tile arrives at O, m_valid <= 0.
- Latency: a tile accepted at edge 0 produces its output at edge DEPTH+1, so m_valid rises DEPTH+1 cycles after the accepting edge if no stall occurs. Throughput is one tile per cycle.
- A vector of exactly one tile (s_last=1 on the first tile) is legal.
- More than MAX_TILES tiles per vector is not an error, but acc wraps modulo 2**W_ACC; the output is defined as that wrapped value, then rounded and saturated.
- Back-to-back vectors need no idle cycle: the accumulator clear on last and the next vector's first tile never collide, because the first tile reaches O one edge later.

Test Plan:
- Defaults, k = identity, x = [1,2,3,4], s_last=1, m_ready=1 -> m_y = [1,2,3,4], m_sat=0, m_valid exactly 3 cycles after accept, high for 1 cycle.
- k all 1, tile0 x = [1,1,1,1] (last=0), tile1 x = [2,2,2,2] (last=1), back-to-back -> one result, every row = 12; a third vector started immediately after is unaffected by the prior accumulation.
- k all -128, x all -128, 4 tiles -> raw 262144 gives m_y rows = 32767, m_sat=1; k = -128, x = 127 -> rows = -32768, m_sat=1.
- SHIFT=2 with single-tile sums 6, -6, 5, -5 -> m_y = 2, -1, 1, -1.
- C=3 (C_PAD=4), k rows [1,2,3], x = [4,5,6] -> 32 per row. Hold m_ready=0 for 5 cycles with tiles streaming -> s_ready=0, m_y stable, no tile dropped or duplicated after release.
- Assert rstn low mid-way through a 3-tile vector, release, send single-tile vector x = [1,1,1,1], k all 1 -> exactly one result = 4, with no stale output from the aborted vector.
